// File: rtl/inst_rom_loader.sv
// Instruction memory: filled once through a valid/ready load port after reset, then serves fetches.
// Fetch latency 1 cycle (registered inst); load accepts one word per cycle.
// ld_ready is high only in LOAD; RUN ignores ld_valid, LOAD ignores fetches.
module inst_rom_loader #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [31:0]   pc,
    output logic [31:0]   inst,
    output logic          busy,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic [AW:0]   ld_cnt,
    output logic          fault
);

    typedef enum logic {S_LOAD, S_RUN} state_t;

    state_t      state;
    logic [31:0] mem [DEPTH];
    logic        ld_acc;
    logic        bad_pc;

    assign busy     = (state == S_LOAD);
    assign ld_ready = (state == S_LOAD);
    assign ld_acc   = ld_valid && ld_ready;
    assign bad_pc   = (pc[1:0] != 2'b00) || (|pc[31:AW+2]);

    // Contents survive reset; a new load simply overwrites them.
    always_ff @(posedge clk) begin
        if (ld_acc) begin
            mem[ld_cnt[AW-1:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_LOAD;
            ld_cnt <= '0;
            inst   <= '0;
            fault  <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    inst <= '0;
                    if (ld_valid) begin
                        ld_cnt <= ld_cnt + 1'b1;
                        // A full array ends the load even without ld_last.
                        if (ld_last || ld_cnt == (AW+1)'(DEPTH - 1)) begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (!ce) begin
                        inst <= '0;
                    end else if (bad_pc) begin
                        inst  <= '0;
                        fault <= 1'b1;
                    end else begin
                        inst <= mem[pc[AW+1:2]];
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule
